// File: rtl/ctl_pkg.sv
// ctl_pkg: shared field positions, class codes, control word and FSM
// state types for the decode/control stage.
package ctl_pkg;

  localparam int COND_LSB = 28;
  localparam int CLS_LSB  = 25;
  localparam int LINK_BIT = 24;
  localparam int BYTE_BIT = 22;
  localparam int OPC_LSB  = 21;
  localparam int RW_BIT   = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RM_LSB   = 0;

  typedef logic [2:0] cls_t;

  localparam cls_t CLS_DP_SHIFT = 3'b000;
  localparam cls_t CLS_DP_IMM   = 3'b001;
  localparam cls_t CLS_LS_IMM   = 3'b010;
  localparam cls_t CLS_LS_REG   = 3'b011;
  localparam cls_t CLS_BRANCH   = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic       se_id;
    logic       li_id;
    logic       rf_id;
    logic       b_id;
    logic       r_w;
    logic       b_l;
    logic       illegal;
    logic [1:0] size;
    logic [3:0] cond;
    logic       s_bit;
  } ctl_t;

  typedef struct packed {
    logic rn;
    logic rm;
    logic rd;
  } rd_mask_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/ctl_decode.sv
// ctl_decode: combinational instruction -> control word decoder,
// plus the mask of register fields the instruction reads.
module ctl_decode
  import ctl_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int REG_AW = 4
) (
  input  logic [31:0]       ir,
  output ctl_t              cw,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_AW-1:0] rn,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rm,
  output rd_mask_t          rmask
);

  cls_t cls;
  logic is_nop;
  logic unused_mid;

  assign cls        = ir[CLS_LSB +: 3];
  assign is_nop     = (ir == 32'd0);
  assign unused_mid = ^ir[11:4];

  // class decode; an all-zero word is a NOP, not a shift-imm DP
  always_comb begin
    cw       = '0;
    opcode   = '0;
    rmask    = '0;
    cw.cond  = ir[COND_LSB +: 4];
    cw.s_bit = ir[S_BIT];
    rn       = ir[RN_LSB +: REG_AW];
    rd       = ir[RD_LSB +: REG_AW];
    rm       = ir[RM_LSB +: REG_AW];
    if (!is_nop) begin
      unique case (1'b1)
        cls == CLS_DP_SHIFT: begin
          cw.se_id = 1'b1;
          opcode   = ir[OPC_LSB +: OPC_W];
          rmask.rn = 1'b1;
          rmask.rm = 1'b1;
        end
        cls == CLS_DP_IMM: begin
          opcode   = ir[OPC_LSB +: OPC_W];
          rmask.rn = 1'b1;
        end
        cls == CLS_LS_IMM: begin
          cw.li_id = 1'b1;
          cw.r_w   = ir[RW_BIT];
          cw.size  = ir[BYTE_BIT] ? SIZE_BYTE : SIZE_WORD;
          rmask.rn = 1'b1;
          rmask.rd = ir[RW_BIT];
        end
        cls == CLS_LS_REG: begin
          cw.li_id = 1'b1;
          cw.rf_id = 1'b1;
          cw.r_w   = ir[RW_BIT];
          cw.size  = ir[BYTE_BIT] ? SIZE_BYTE : SIZE_WORD;
          rmask.rn = 1'b1;
          rmask.rm = 1'b1;
          rmask.rd = ir[RW_BIT];
        end
        cls == CLS_BRANCH: begin
          cw.b_id = 1'b1;
          cw.b_l  = ir[LINK_BIT];
        end
        default: cw.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_control_stage.sv
// id_control_stage: decode + ID/EX register with handshake, stall hold,
// flush bubble and load-use hazard bubble insertion.
module id_control_stage
  import ctl_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int OPC_W     = 4,
  parameter int REG_AW    = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] ir_in,
  input  logic               ir_valid,
  output logic               ir_ready,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               ctl_valid,
  output logic               se_id,
  output logic               li_id,
  output logic               rf_id,
  output logic               b_id,
  output logic               r_w,
  output logic               b_l,
  output logic [OPC_W-1:0]   opcode,
  output logic [1:0]         size,
  output logic [3:0]         cond,
  output logic               s_bit,
  output logic [REG_AW-1:0]  rn,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rm,
  output logic               illegal,
  output logic               hazard_stall
);

  ctl_t              cw_d, cw_q;
  logic [OPC_W-1:0]  opc_d, opc_q;
  logic [REG_AW-1:0] rn_d, rd_d, rm_d;
  logic [REG_AW-1:0] rn_q, rd_q, rm_q;
  rd_mask_t          rmask;
  logic              vld_q;
  state_t            state_q, state_d;
  logic              load_q, hit, hazard;
  logic              upd, take;

  ctl_decode #(
    .OPC_W  (OPC_W),
    .REG_AW (REG_AW)
  ) u_dec (
    .ir     (ir_in[31:0]),
    .cw     (cw_d),
    .opcode (opc_d),
    .rn     (rn_d),
    .rd     (rd_d),
    .rm     (rm_d),
    .rmask  (rmask)
  );

  // load-use: registered load whose rd the incoming word reads
  always_comb begin
    load_q = vld_q & cw_q.li_id & ~cw_q.r_w;
    hit    = (rmask.rn & (rn_d == rd_q))
           | (rmask.rm & (rm_d == rd_q))
           | (rmask.rd & (rd_d == rd_q));
    hazard = HAZARD_EN & (state_q == RUN)
           & load_q & ir_valid & hit;
  end

  // next state and register update: flush > stall > hazard > accept
  always_comb begin
    state_d      = state_q;
    upd          = 1'b1;
    take         = 1'b0;
    hazard_stall = 1'b0;
    ir_ready     = (~ex_stall & ~hazard) | flush;
    if (flush) begin
      state_d = RUN;
    end else if (ex_stall) begin
      upd = 1'b0;
    end else if (hazard) begin
      hazard_stall = 1'b1;
      state_d      = BUBBLE;
    end else if (ir_valid) begin
      take    = 1'b1;
      state_d = RUN;
    end
  end

  // FSM state and ID/EX register; a bubble clears every field
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      vld_q   <= 1'b0;
      cw_q    <= '0;
      opc_q   <= '0;
      rn_q    <= '0;
      rd_q    <= '0;
      rm_q    <= '0;
    end else begin
      state_q <= state_d;
      if (upd) begin
        vld_q <= take;
        if (take) begin
          cw_q  <= cw_d;
          opc_q <= opc_d;
          rn_q  <= rn_d;
          rd_q  <= rd_d;
          rm_q  <= rm_d;
        end else begin
          cw_q  <= '0;
          opc_q <= '0;
          rn_q  <= '0;
          rd_q  <= '0;
          rm_q  <= '0;
        end
      end
    end
  end

  assign ctl_valid = vld_q;
  assign se_id     = cw_q.se_id;
  assign li_id     = cw_q.li_id;
  assign rf_id     = cw_q.rf_id;
  assign b_id      = cw_q.b_id;
  assign r_w       = cw_q.r_w;
  assign b_l       = cw_q.b_l;
  assign illegal   = cw_q.illegal;
  assign size      = cw_q.size;
  assign cond      = cw_q.cond;
  assign s_bit     = cw_q.s_bit;
  assign opcode    = opc_q;
  assign rn        = rn_q;
  assign rd        = rd_q;
  assign rm        = rm_q;

endmodule

// File: doc/id_control_stage.md
# id_control_stage

Parametrised second-generation decode/control stage: decodes one instruction per cycle into the control word, registers it into the ID/EX pipeline boundary, and adds behaviour the combinational decoder lacks. New behaviour: valid/ready handshake toward fetch, EX-driven stall hold, flush bubble insertion, illegal-class flagging, and automatic load-use hazard detection with a one-cycle bubble. It sits between the IF/ID register and the EX stage.

## Interface
- INSTR_W, 32, instruction width (≥32; fields at fixed bit positions, upper extra bits ignored)
- OPC_W, 4, opcode field width
- REG_AW, 4, register-index width
- HAZARD_EN, 1, 1 = load-use detection active; 0 = never stalls on hazard
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ir_in  in  INSTR_W  instruction from IF/ID
- ir_valid  in  1  ir_in holds a real instruction
- ir_ready  out  1  stage accepts ir_in this cycle (combinational)
- ex_stall  in  1  EX cannot take a new control word; hold outputs
- flush  in  1  discard in-flight and incoming instruction (branch taken)
- ctl_valid  out  1  registered control word is live
- se_id, li_id, rf_id, b_id, r_w, b_l  out  1 each  registered control bits
- opcode  out  OPC_W  registered ALU opcode
- size  out  2  00 byte, 10 word
- cond  out  4  ir[31:28]; s_bit  out  1  ir[20]
- rn, rd, rm  out  REG_AW each  ir[19:16], ir[15:12], ir[3:0]
- illegal  out  1  registered word came from an undefined class
- hazard_stall  out  1  load-use bubble being inserted (to IF hold)

## Operation
- Decode by class ir[27:25]: 000 shift-imm DP (se_id=1, opcode=ir[24:21]); 001 imm DP (opcode=ir[24:21]); 010 LS imm (li_id=1); 011 LS reg (li_id=1, rf_id=1); 101 branch (b_id=1, b_l=ir[24]). For LS: r_w=ir[21] (0 read/load, 1 write/store); size=00 if ir[22] else 10. Non-LS: size=00, r_w=0.
- ir_in==0: NOP, all control bits/fields 0, ctl_valid=1.
- Classes 100, 110, 111: all control bits 0, illegal=1, ctl_valid=1.
- Load-use hazard (HAZARD_EN=1): registered word is a load (ctl_valid & li_id & !r_w) and incoming valid non-NOP non-branch instruction reads its rd. Reads: rn for classes 000/001/010/011; rm for 000/011; rd for stores.
- FSM states RUN, BUBBLE. RUN + hazard + !ex_stall + !flush: register bubble (ctl_valid=0, all fields 0), ir_ready=0, hazard_stall=1, go BUBBLE. BUBBLE: no hazard check; accept held instruction normally; go RUN on accept.
- Priority per cycle: reset > flush > ex_stall > hazard > normal accept.
- flush: next register = bubble, state → RUN, ir_ready=1, incoming instruction discarded.
- ex_stall (no flush): output register and state hold, ir_ready=0, hazard_stall=0.
- ir_valid=0 with no stall/flush: register bubble, state unchanged.

## Timing
- Latency 1 cycle: instruction accepted on edge N appears on outputs after edge N.
- ir_ready = !ex_stall & !(state==RUN & hazard) | flush; purely combinational from inputs and registered state.
- hazard_stall asserted only in the cycle the bubble is registered.
- Reset (async assert, sync-safe deassert): all outputs 0, ctl_valid=0, illegal=0, state RUN.
- Reset mid-bubble: returns to RUN; held instruction must be re-presented by IF.
- Hazard and ex_stall same cycle: stall wins, hazard re-evaluated next cycle.

## Structure
- Package ctl_pkg: field bit positions, class codes (CLS_DP_SHIFT, CLS_DP_IMM, CLS_LS_IMM, CLS_LS_REG, CLS_BRANCH), SIZE_BYTE/SIZE_WORD, control-word struct, FSM state enum.
- Sub-module ctl_decode: pure combinational instruction→control-word decoder, including register-read mask; the stage instantiates it and owns FSM, hazard compare and pipeline register.

## Test plan
- Reset, then 0xE2811001 valid → next cycle ctl_valid=1, opcode=0100, rn=1, rd=1, all control bits 0.
- 0xE5912000 then 0xE2823001 back-to-back → load registered (li_id=1, r_w=0, size=10, rd=2); next cycle bubble, hazard_stall=1, ir_ready=0; following cycle ADD registered with rn=2.
- Same sequence with HAZARD_EN=0 → no bubble, ADD registered immediately after load.
- 0xEB000004 then ex_stall=1 for 3 cycles → b_id=1, b_l=1 held constant, ir_ready=0 throughout.
- Hazard pending plus flush=1 in same cycle → bubble registered, state RUN, hazard_stall=0; 0xE8000000 next → illegal=1, ctl_valid=1.
- 0x00000000 → ctl_valid=1, all control/fields 0; reset_n pulsed low mid-BUBBLE → outputs 0 immediately, state RUN.
